// File: rtl/uio_byte_tx.sv
// Transmit side of the uio pin bus: byte FIFO from the core, bus turnaround control and
// a two-phase req/ack toggle handshake towards an external peer, with ack timeout abort.
module uio_byte_tx #(
  parameter int DEPTH   = 4,
  parameter int TURN    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  // Core side: a byte is taken on every rising edge where in_valid && in_ready.
  // in_ready depends only on registered FIFO fill, never on in_valid.
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic       tx_req,
  input  logic       tx_ack,
  output logic       tx_last,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(TURN + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    WAIT_ACK = 3'd2,
    STALL    = 3'd3,
    TURN_OFF = 3'd4
  } state_t;

  state_t          state_q;
  logic [8:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]   wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   tmo_q;
  logic [7:0]      out_q, oe_q;
  logic            req_q, last_q, busy_q, err_q, rdy_q;

  logic [PW-1:0]   fill, fill_d;
  logic            empty, full, ack_seen, pop, tmo_hit, wr_en;
  logic [AW-1:0]   rd_nxt;
  logic [8:0]      head, nxt;

  always_comb begin
    fill     = wr_ptr_q - rd_ptr_q;
    empty    = (fill == '0);
    full     = (fill == PW'(DEPTH));
    head     = mem_q[rd_ptr_q[AW-1:0]];
    rd_nxt   = rd_ptr_q[AW-1:0] + AW'(1);
    nxt      = mem_q[rd_nxt];
    ack_seen = (tx_ack == req_q);
    pop      = (state_q == WAIT_ACK) && ack_seen;
    // Ack arriving on the timeout cycle still counts as a normal handshake.
    tmo_hit  = (state_q == WAIT_ACK) && !ack_seen && (tmo_q == TW'(TIMEOUT));
    wr_en    = in_valid && !full && !tmo_hit;
    wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    if (tmo_hit) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fill_d   = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      out_q    <= 8'h00;
      oe_q     <= 8'h00;
      req_q    <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= (fill_d != PW'(DEPTH));
      if (tmo_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          // ack==req also swallows a late ack left over from an aborted byte.
          if (!empty && ack_seen) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
            oe_q    <= 8'hFF;
            out_q   <= head[7:0];
            last_q  <= head[8];
            cnt_q   <= CW'(TURN - 1);
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            req_q   <= ~req_q;
            tmo_q   <= '0;
            state_q <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        WAIT_ACK: begin
          if (ack_seen) begin
            if (head[8]) begin
              state_q <= TURN_OFF;
              oe_q    <= 8'h00;
              out_q   <= 8'h00;
              last_q  <= 1'b0;
              cnt_q   <= CW'(TURN - 1);
            end else if (fill > PW'(1)) begin
              state_q <= SETUP;
              out_q   <= nxt[7:0];
              last_q  <= nxt[8];
              cnt_q   <= '0;
            end else begin
              state_q <= STALL;
            end
          end else if (tmo_hit) begin
            state_q <= TURN_OFF;
            oe_q    <= 8'h00;
            out_q   <= 8'h00;
            last_q  <= 1'b0;
            cnt_q   <= CW'(TURN - 1);
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        STALL: begin
          if (!empty) begin
            state_q <= SETUP;
            out_q   <= head[7:0];
            last_q  <= head[8];
            cnt_q   <= '0;
          end
        end
        TURN_OFF: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign uio_out  = out_q;
  assign uio_oe   = oe_q;
  assign tx_req   = req_q;
  assign tx_last  = last_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uio_byte_tx.sv
// Bench for uio_byte_tx: cycle table for a single-byte frame, directed corner sequences,
// and random traffic checked against a byte-order scoreboard with an emulated peer.
module tb_uio_byte_tx;
  localparam int DEPTH   = 4;
  localparam int TURN    = 2;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       tx_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       in_ready, tx_req, tx_last, busy, err;
  logic [7:0] uio_out, uio_oe;

  always #5 clk = ~clk;

  uio_byte_tx #(.DEPTH(DEPTH), .TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .uio_out(uio_out), .uio_oe(uio_oe), .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_last(tx_last), .busy(busy), .err(err), .err_clr(err_clr)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       last;
    logic       ack;
    logic [7:0] e_out;
    logic       e_oe;
    logic       e_req;
    logic       e_last;
    logic       e_busy;
    logic       e_rdy;
  } vec_t;

  vec_t       tbl [8];
  logic [8:0] exp_q [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_req = 0;
  bit         auto_ack = 1'b0;
  int         lat_max = 0;
  bit         ack_pend = 1'b0;
  int         ack_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: record accepted bytes, step, then check every req edge against the queue.
  task automatic tick();
    logic       acc, pre_req, rst_was;
    logic [7:0] pre_out;
    logic [8:0] e;
    acc     = in_valid && in_ready && !rst;
    rst_was = rst;
    pre_out = uio_out;
    pre_req = tx_req;
    if (acc) exp_q.push_back({in_last, in_data});
    @(posedge clk);
    #1;
    if (rst_was) begin
      exp_q.delete();
      ack_pend = 1'b0;
    end else if (tx_req != pre_req) begin
      n_req++;
      check("req_setup", 32'({pre_out, uio_oe}), 32'({uio_out, 8'hFF}));
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL req_unexp: got byte 0x%0h last %0b, required no req edge at %0t",
                 uio_out, tx_last, $time);
      end else begin
        e = exp_q.pop_front();
        check("req_byte", 32'({tx_last, uio_out}), 32'(e));
      end
      if (auto_ack) begin
        ack_pend = 1'b1;
        ack_cnt  = $urandom_range(0, lat_max);
      end
    end
    check("oe_level", 32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 32'(1));
    if (uio_oe == 8'h00) check("bus_idle", 32'({tx_last, uio_out}), 32'(0));
    if (auto_ack && ack_pend) begin
      if (ack_cnt == 0) begin
        tx_ack   = tx_req;
        ack_pend = 1'b0;
      end else begin
        ack_cnt--;
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_req(input int lim);
    int n0 = n_req;
    int k  = 0;
    while (n_req == n0 && k < lim) begin
      tick();
      k++;
    end
    check("wait_req", 32'(n_req != n0), 32'(1));
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < lim) begin
      tick();
      k++;
    end
    check("drain_busy", 32'(busy), 32'(0));
    check("drain_q", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, drop, k;
    logic hold_req;

    // Single-byte frame A5(last), ack two cycles after the req edge.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Clock/reset
    tick();
    tick();
    rst = 1'b0;
    check("reset", 32'({uio_out, uio_oe, tx_req, tx_last, busy, err, in_ready}), 32'(1));

    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      in_last  = tbl[i].last;
      tx_ack   = tbl[i].ack;
      tick();
      check($sformatf("vec%0d", i),
            32'({uio_out, uio_oe == 8'hFF, tx_req, tx_last, busy, in_ready}),
            32'({tbl[i].e_out, tbl[i].e_oe, tbl[i].e_req, tbl[i].e_last, tbl[i].e_busy,
                 tbl[i].e_rdy}));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Three-byte frame with instant ack: oe must stay on across all bytes.
    auto_ack = 1'b1;
    lat_max  = 0;
    n0   = n_req;
    drop = 0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b1);
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 60) begin
      tick();
      k++;
      if (n_req - n0 >= 1 && n_req - n0 < 3 && uio_oe != 8'hFF) drop++;
    end
    check("frame_toggles", 32'(n_req - n0), 32'(3));
    check("frame_oe_held", 32'(drop), 32'(0));
    check("frame_idle", 32'(busy), 32'(0));

    // Fill the FIFO with the peer silent.
    auto_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i), (i == DEPTH - 1));
    check("full_ready", 32'(in_ready), 32'(0));
    push(8'hEE, 1'b0);
    check("refused_ready", 32'(in_ready), 32'(0));
    k = 0;
    while (tx_req == tx_ack && k < 10) begin
      tick();
      k++;
    end
    check("waitack_reached", 32'(tx_req != tx_ack), 32'(1));
    check("full_hold", 32'(in_ready), 32'(0));
    tx_ack = tx_req;
    tick();
    check("ack_frees", 32'(in_ready), 32'(1));
    auto_ack = 1'b1;
    lat_max  = 2;
    drain(200);

    // Mid-frame underrun holds the bus.
    lat_max = 0;
    push(8'h44, 1'b0);
    wait_req(20);
    tick();
    hold_req = tx_req;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 32'({uio_oe, uio_out, tx_req, busy}),
            32'({8'hFF, 8'h44, hold_req, 1'b1}));
    end
    push(8'h55, 1'b1);
    drain(50);
    check("post_stall_oe", 32'(uio_oe), 32'(0));

    // Ack timeout: flush (including a same-cycle write), abort, late ack absorbed.
    auto_ack = 1'b0;
    push(8'h66, 1'b1);
    wait_req(20);
    for (int i = 0; i < TIMEOUT; i++) begin
      in_valid = (i < 2);
      in_data  = (i == 0) ? 8'h77 : 8'h88;
      tick();
    end
    in_valid = 1'b0;
    check("err_early", 32'(err), 32'(0));
    in_valid = 1'b1;
    in_data  = 8'hBB;
    tick();
    in_valid = 1'b0;
    check("err_set", 32'(err), 32'(1));
    check("abort_oe", 32'(uio_oe), 32'(0));
    check("abort_ready", 32'(in_ready), 32'(1));
    exp_q.delete();
    k = 0;
    while (busy && k < 10) begin
      tick();
      k++;
    end
    check("abort_idle", 32'(busy), 32'(0));
    tx_ack = tx_req;
    repeat (4) tick();
    check("late_ack_idle", 32'(busy), 32'(0));
    check("err_sticky", 32'(err), 32'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'(0));
    auto_ack = 1'b1;
    push(8'h99, 1'b1);
    drain(50);

    // Reset while waiting for ack.
    auto_ack = 1'b0;
    push(8'hCC, 1'b0);
    wait_req(20);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hDD;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_mid", 32'({uio_oe, uio_out, tx_req, tx_last, busy, in_ready, err}),
          32'({8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
    tx_ack = 1'b0;
    repeat (4) tick();
    check("rst_fifo_empty", 32'(busy), 32'(0));

    // Random traffic against the scoreboard with a variable-latency peer.
    auto_ack = 1'b1;
    lat_max  = 3;
    for (int c = 0; c < 500; c++) begin
      if (in_ready && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(0, 255));
        in_last  = ($urandom_range(0, 3) == 0);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    k = 0;
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    push(8'h5A, 1'b1);
    drain(3000);
    check("final_oe", 32'(uio_oe), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
